fw_hazard_ctrl: RTL and testbench

// Forwarding/hazard controller for the 5-stage segmented core. Shadows the destination registers of
// the instructions in EX, MEM and WB, and drives the 2-bit selects of the two MuxFw operand muxes
// (ALU A, ALU B) for the instruction in EX. Also produces the load-use stall and bubble request for ID.

---
 rtl/fw_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_fw_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_hazard_ctrl.sv
// Forwarding select and load-use hazard controller for the 5-stage core.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fw_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              pipe_hold,
  input  logic              flush,
  output logic              stall_id,
  output logic [1:0]        fw_sel_a,
  output logic [1:0]        fw_sel_b
`ifdef FWD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stalls,
  output logic [STAT_W-1:0] stat_fwd_mem,
  output logic [STAT_W-1:0] stat_fwd_wb
`endif
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_MEM = 2'b11;

  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_we, mem_we, wb_we;
  logic              ex_ld, mem_ld;
  logic [1:0]        sel_a_n, sel_b_n;
  logic              issue;

  // The instruction now in EX will sit in EX/MEM when the ID instruction reaches EX,
  // and the one in MEM will sit in MEM/WB, hence 11 / 10.
  function automatic logic [1:0] fwd_sel(input logic              use_s,
                                         input logic [REG_AW-1:0] s,
                                         input logic [REG_AW-1:0] e_rd,
                                         input logic              e_we,
                                         input logic [REG_AW-1:0] m_rd,
                                         input logic              m_we);
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_s && (s != '0)) begin
      if (e_we && (s == e_rd))      sel = SEL_MEM;
      else if (m_we && (s == m_rd)) sel = SEL_WB;
    end
    return sel;
  endfunction

  assign stall_id = id_valid && ex_ld && ex_we && !flush &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign issue    = id_valid && !flush && !stall_id;
  assign sel_a_n  = fwd_sel(id_use_rs1, id_rs1, ex_rd, ex_we, mem_rd, mem_we);
  assign sel_b_n  = fwd_sel(id_use_rs2, id_rs2, ex_rd, ex_we, mem_rd, mem_we);

  // ID -> EX -> MEM -> WB shadow pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd    <= '0;
      ex_we    <= 1'b0;
      ex_ld    <= 1'b0;
      mem_rd   <= '0;
      mem_we   <= 1'b0;
      mem_ld   <= 1'b0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      fw_sel_a <= SEL_RF;
      fw_sel_b <= SEL_RF;
    end else if (!pipe_hold) begin
      wb_rd  <= mem_rd;
      wb_we  <= mem_we;
      mem_rd <= ex_rd;
      mem_we <= ex_we;
      mem_ld <= ex_ld;
      if (issue) begin
        ex_rd    <= id_rd;
        ex_we    <= id_regwrite && (id_rd != '0);
        ex_ld    <= id_memread;
        fw_sel_a <= sel_a_n;
        fw_sel_b <= sel_b_n;
      end else begin
        ex_rd    <= '0;
        ex_we    <= 1'b0;
        ex_ld    <= 1'b0;
        fw_sel_a <= SEL_RF;
        fw_sel_b <= SEL_RF;
      end
    end
  end

  // WB and MEM-load shadows are kept for visibility only; nothing downstream consumes them.
  logic unused_shadow;
  assign unused_shadow = ^{wb_rd, wb_we, mem_ld};

`ifdef FWD_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] cnt,
                                                input logic [1:0]        inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, cnt} + {{(STAT_W-1){1'b0}}, inc};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

  logic [1:0] n_mem, n_wb;
  assign n_mem = {1'b0, issue && (sel_a_n == SEL_MEM)} + {1'b0, issue && (sel_b_n == SEL_MEM)};
  assign n_wb  = {1'b0, issue && (sel_a_n == SEL_WB)}  + {1'b0, issue && (sel_b_n == SEL_WB)};

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stalls  <= '0;
      stat_fwd_mem <= '0;
      stat_fwd_wb  <= '0;
    end else if (!pipe_hold) begin
      stat_stalls  <= sat_inc(stat_stalls, {1'b0, stall_id});
      stat_fwd_mem <= sat_inc(stat_fwd_mem, n_mem);
      stat_fwd_wb  <= sat_inc(stat_fwd_wb, n_wb);
    end
  end
`endif

endmodule

// File: tb/tb_fw_hazard_ctrl.sv
// Bench for fw_hazard_ctrl: per-cycle ID stimulus rows, expected EX selects queued at
// drive time and popped one clock later when the instruction occupies EX.
module tb_fw_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, pipe_hold, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_id;
  logic [1:0] fw_sel_a, fw_sel_b;
`ifdef FWD_STATS_EN
  logic [15:0] stat_stalls, stat_fwd_mem, stat_fwd_wb;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  typedef struct packed {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2; logic [4:0] rd;
    logic we; logic ld; logic hold; logic fl; logic rst; logic es; logic [1:0] ea; logic [1:0] eb;
  } row_t;

  fw_hazard_ctrl #(.REG_AW(5), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .pipe_hold(pipe_hold), .flush(flush), .stall_id(stall_id),
    .fw_sel_a(fw_sel_a), .fw_sel_b(fw_sel_b)
`ifdef FWD_STATS_EN
    , .stat_stalls(stat_stalls), .stat_fwd_mem(stat_fwd_mem), .stat_fwd_wb(stat_fwd_wb)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish got running want done");
    $fatal(1, "timeout");
  end

  // es < 0 means stall_id is not checked on that row.
  function automatic row_t mk(int v, int rs1, int u1, int rs2, int u2, int rd, int we, int ld,
                              int hold, int fl, int rst, int es, int ea, int eb);
    row_t x;
    x.v = v[0]; x.rs1 = rs1[4:0]; x.u1 = u1[0]; x.rs2 = rs2[4:0]; x.u2 = u2[0];
    x.rd = rd[4:0]; x.we = we[0]; x.ld = ld[0]; x.hold = hold[0]; x.fl = fl[0];
    x.rst = rst[0]; x.es = (es < 0) ? 1'bx : es[0]; x.ea = ea[1:0]; x.eb = eb[1:0];
    return x;
  endfunction

  function automatic row_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic run_row(input row_t rw, output logic st, output logic [3:0] got,
                         output logic [3:0] exp);
    id_valid = rw.v; id_rs1 = rw.rs1; id_use_rs1 = rw.u1; id_rs2 = rw.rs2; id_use_rs2 = rw.u2;
    id_rd = rw.rd; id_regwrite = rw.we; id_memread = rw.ld; pipe_hold = rw.hold;
    flush = rw.fl; reset = rw.rst;
    #3;
    st = stall_id;
    sb.push_back({rw.ea, rw.eb});
    @(posedge clk);
    #1;
    got = {fw_sel_a, fw_sel_b};
    exp = (sb.size() != 0) ? sb.pop_front() : 4'bxxxx;
  endtask

  task automatic test_reset();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      if (t[i].es !== 1'bx) begin
        checks++;
        if (st !== t[i].es) begin errors++; $display("FAIL reset[%0d] stall_id got %b want %b", i, st, t[i].es); end
      end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

  task automatic test_fwd_ex();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 5, 1, 6, 1, 9, 1, 0, 0, 0, 0, 0, 3, 0));
    t.push_back(idle());
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      checks++;
      if (st !== t[i].es) begin errors++; $display("FAIL fwd_ex[%0d] stall_id got %b want %b", i, st, t[i].es); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL fwd_ex[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

  task automatic test_fwd_mem();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 3, 1, 4, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 1, 7, 1, 10, 1, 0, 0, 0, 0, 0, 0, 2));
    t.push_back(idle());
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      checks++;
      if (st !== t[i].es) begin errors++; $display("FAIL fwd_mem[%0d] stall_id got %b want %b", i, st, t[i].es); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL fwd_mem[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

  task automatic test_load_use();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 3, 1, 4, 1, 11, 1, 0, 0, 0, 0, 1, 0, 0));
    t.push_back(mk(1, 3, 1, 4, 1, 11, 1, 0, 0, 0, 0, 0, 2, 0));
    t.push_back(idle());
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      checks++;
      if (st !== t[i].es) begin errors++; $display("FAIL load_use[%0d] stall_id got %b want %b", i, st, t[i].es); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL load_use[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

  task automatic test_same_src();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 9, 1, 9, 1, 12, 1, 0, 0, 0, 0, 0, 3, 3));
    t.push_back(mk(1, 12, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    t.push_back(idle());
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      checks++;
      if (st !== t[i].es) begin errors++; $display("FAIL same_src[%0d] stall_id got %b want %b", i, st, t[i].es); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL same_src[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

  task automatic test_x0_flush();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(idle());
    t.push_back(idle());
    t.push_back(mk(1, 1, 1, 2, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 9, 1, 2, 1, 10, 1, 0, 0, 1, 0, 0, 0, 0));
    t.push_back(mk(1, 10, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    t.push_back(idle());
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      checks++;
      if (st !== t[i].es) begin errors++; $display("FAIL x0_flush[%0d] stall_id got %b want %b", i, st, t[i].es); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL x0_flush[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

  task automatic test_hold();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(1, 1, 1, 2, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 11, 1, 2, 1, 12, 1, 0, 0, 0, 0, 0, 3, 0));
    for (int k = 0; k < 3; k++) t.push_back(mk(1, 11, 1, 12, 1, 13, 1, 0, 1, 0, 0, 0, 3, 0));
    t.push_back(mk(1, 11, 1, 12, 1, 13, 1, 0, 0, 0, 0, 0, 2, 3));
    t.push_back(idle());
    t.push_back(idle());
    t.push_back(mk(1, 1, 1, 2, 1, 13, 1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) t.push_back(mk(1, 13, 1, 2, 1, 14, 1, 0, 1, 0, 0, 1, 0, 0));
    t.push_back(mk(1, 13, 1, 2, 1, 14, 1, 0, 0, 0, 0, 1, 0, 0));
    t.push_back(mk(1, 13, 1, 2, 1, 14, 1, 0, 0, 0, 0, 0, 2, 0));
    t.push_back(idle());
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      checks++;
      if (st !== t[i].es) begin errors++; $display("FAIL hold[%0d] stall_id got %b want %b", i, st, t[i].es); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL hold[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t t[$]; logic st; logic [3:0] got, exp;
    t.push_back(mk(1, 1, 1, 2, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 1, 2, 1, 15, 1, 1, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 15, 1, 14, 1, 16, 1, 0, 0, 0, 1, 1, 0, 0));
    t.push_back(mk(1, 15, 1, 14, 1, 16, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(idle());
    foreach (t[i]) begin
      run_row(t[i], st, got, exp);
      checks++;
      if (st !== t[i].es) begin errors++; $display("FAIL rst_stall[%0d] stall_id got %b want %b", i, st, t[i].es); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_stall[%0d] sel got %b want %b", i, got, exp); end
    end
  endtask

`ifdef FWD_STATS_EN
  task automatic test_stats(input int e_st, input int e_mem, input int e_wb, input string tag);
    checks++;
    if (stat_stalls !== 16'(e_st)) begin errors++; $display("FAIL %s stat_stalls got %0d want %0d", tag, stat_stalls, e_st); end
    checks++;
    if (stat_fwd_mem !== 16'(e_mem)) begin errors++; $display("FAIL %s stat_fwd_mem got %0d want %0d", tag, stat_fwd_mem, e_mem); end
    checks++;
    if (stat_fwd_wb !== 16'(e_wb)) begin errors++; $display("FAIL %s stat_fwd_wb got %0d want %0d", tag, stat_fwd_wb, e_wb); end
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
`ifdef FWD_STATS_EN
    test_stats(1, 1, 2, "stats_after_1to3");
`endif
    test_same_src();
    test_x0_flush();
    test_hold();
    test_reset_mid_stall();
`ifdef FWD_STATS_EN
    test_stats(0, 0, 0, "stats_after_reset");
`endif
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
